// File: rtl/matriz_pkg.sv
// Shared types and constants for the LED matrix column controller.
// Holds the matrix geometry, the scan state encoding and the column bitmap
// type used by the frame buffers.
package matriz_pkg;

  localparam int N_COLS = 5;
  localparam int N_ROWS = 7;

  // Index of the last column; advancing from here wraps to column 0 and
  // marks a frame boundary.
  localparam logic [2:0] ULTIMA_COL = 3'(N_COLS - 1);

  // One column of the display; bit 6 is row l0.
  typedef logic [N_ROWS-1:0] coluna_t;

  typedef enum logic [1:0] {
    DESLIGADO,
    APAGADO,
    ACESO
  } estado_t;

  function automatic logic [2:0] proxima_coluna(input logic [2:0] col);
    return (col == ULTIMA_COL) ? 3'd0 : col + 3'd1;
  endfunction

endpackage

// File: rtl/controlador_matriz_if.sv
// Producer-side bus of the matrix controller: back-buffer column writes
// (valid/ready) and the swap request/acknowledge pair.
// Signals:
//   wr_valid  producer has a column write
//   wr_ready  back buffer accepts writes
//   wr_col    back-buffer column index, 0..4
//   wr_data   column bitmap, bit 6 = row l0
//   swap_req  one-cycle request to publish the back buffer
//   swap_ack  one-cycle pulse when the swap is performed
// Modports: master = producer (game/pattern logic), slave = controller.
interface controlador_matriz_if;
  import matriz_pkg::*;

  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_col;
  coluna_t    wr_data;
  logic       swap_req;
  logic       swap_ack;

  modport master (
    output wr_valid, wr_col, wr_data, swap_req,
    input  wr_ready, swap_ack
  );

  modport slave (
    input  wr_valid, wr_col, wr_data, swap_req,
    output wr_ready, swap_ack
  );

endinterface

// File: rtl/controlador_matriz_prescaler.sv
// Column-period prescaler for the matrix scan.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   clear       forces the count back to 0 (has priority over run)
//   run         advances the count; it wraps from DIV_MAX to 0
//   count       current position inside the column period
//   tick        high while count == DIV_MAX (last clock of the period)
module prescaler_varredura #(
  parameter int DIV_WIDTH = 16,
  parameter int DIV_MAX   = 49999
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 run,
  output logic [DIV_WIDTH-1:0] count,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] MAX_COUNT = DIV_WIDTH'(DIV_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= (count == MAX_COUNT) ? '0 : count + DIV_WIDTH'(1);
    end
  end

  assign tick = (count == MAX_COUNT);

endmodule

// File: rtl/controlador_matriz.sv
// Column-scan sequencer and double-buffered frame store for the 7x5 LED
// matrix driver. The producer fills the back buffer through the write port
// and requests a swap; the back buffer is copied to the front buffer only
// at a frame boundary (column 4 -> 0), so a frame is never shown half-updated.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   ativar          display on; 0 blanks the display and parks the scan
//   wr              producer bus (writes + swap handshake), slave side
//   frame_done      one-cycle pulse after each completed 5-column frame
//   contador        column index to the matrix driver
//   enable          column enable; low for BLANK_CYCLES at each column start
//   mapa0..mapa4    front-buffer columns 0..4
module controlador_matriz
  import matriz_pkg::*;
#(
  parameter int DIV_WIDTH    = 16,
  parameter int DIV_MAX      = 49999,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ativar,
  controlador_matriz_if.slave  wr,
  output logic                 frame_done,
  output logic [2:0]           contador,
  output logic                 enable,
  output coluna_t              mapa0,
  output coluna_t              mapa1,
  output coluna_t              mapa2,
  output coluna_t              mapa3,
  output coluna_t              mapa4
);

  // The FSM leaves APAGADO on the edge where the prescaler becomes
  // BLANK_CYCLES, i.e. while it still reads BLANK_CYCLES-1.
  localparam logic [DIV_WIDTH-1:0] BLANK_LAST = DIV_WIDTH'(BLANK_CYCLES - 1);

  estado_t              state;
  estado_t              state_next;
  logic [DIV_WIDTH-1:0] presc;
  logic                 presc_tick;
  logic                 presc_clear;
  logic                 presc_run;
  logic                 col_step;
  logic                 wrap;
  logic                 swap_fire;
  logic                 pending;
  logic                 wr_accept;
  coluna_t              back  [N_COLS];
  coluna_t              front [N_COLS];

  prescaler_varredura #(
    .DIV_WIDTH (DIV_WIDTH),
    .DIV_MAX   (DIV_MAX)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .clear (presc_clear),
    .run   (presc_run),
    .count (presc),
    .tick  (presc_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DESLIGADO;
    end else begin
      state <= state_next;
    end
  end

  // Dropping ativar always wins over a column step, so turning the display
  // off on the last clock of column 4 does not count as a frame boundary.
  always_comb begin
    state_next  = state;
    presc_clear = 1'b0;
    presc_run   = 1'b0;
    col_step    = 1'b0;
    unique case (state)
      DESLIGADO: begin
        presc_clear = 1'b1;
        if (ativar) state_next = APAGADO;
      end
      APAGADO: begin
        if (!ativar) begin
          state_next  = DESLIGADO;
          presc_clear = 1'b1;
        end else begin
          presc_run = 1'b1;
          if (presc == BLANK_LAST) state_next = ACESO;
        end
      end
      ACESO: begin
        if (!ativar) begin
          state_next  = DESLIGADO;
          presc_clear = 1'b1;
        end else begin
          presc_run = 1'b1;
          if (presc_tick) begin
            state_next = APAGADO;
            col_step   = 1'b1;
          end
        end
      end
      default: begin
        state_next  = DESLIGADO;
        presc_clear = 1'b1;
      end
    endcase
  end

  assign wrap      = col_step && (contador == ULTIMA_COL);
  assign swap_fire = wrap && (pending || wr.swap_req);
  assign wr_accept = wr.wr_valid && !pending;

  assign wr.wr_ready = !pending;

  // enable is registered from the next state so it falls on the same edge
  // that contador changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      contador    <= 3'd0;
      enable      <= 1'b0;
      frame_done  <= 1'b0;
      wr.swap_ack <= 1'b0;
    end else begin
      if (state_next == DESLIGADO) begin
        contador <= 3'd0;
      end else if (col_step) begin
        contador <= proxima_coluna(contador);
      end
      enable      <= (state_next == ACESO);
      frame_done  <= wrap;
      wr.swap_ack <= swap_fire;
    end
  end

  // A swap request arriving on the boundary edge itself is served right
  // away, so pending is never seen high in that case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (swap_fire) begin
      pending <= 1'b0;
    end else if (wr.swap_req) begin
      pending <= 1'b1;
    end
  end

  // Writes to column indices above 4 are handshaken but dropped. The front
  // copy takes the back buffer as it was before this edge's write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_COLS; i++) begin
        back[i]  <= '0;
        front[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_COLS; i++) begin
        if (wr_accept && (wr.wr_col == 3'(i))) back[i] <= wr.wr_data;
        if (swap_fire) front[i] <= back[i];
      end
    end
  end

  assign mapa0 = front[0];
  assign mapa1 = front[1];
  assign mapa2 = front[2];
  assign mapa3 = front[3];
  assign mapa4 = front[4];

endmodule

// File: tb/tb_controlador_matriz.sv
// Testbench for controlador_matriz with 10-clock columns and 2 blanking
// clocks. A time-based reference model (clocks since activation) predicts
// the scan outputs; a buffer/pending model predicts the handshake and mapa.
module tb_controlador_matriz;
  import matriz_pkg::*;

  localparam int DIV_MAX    = 9;
  localparam int BLANK      = 2;
  localparam int COL_CLKS   = DIV_MAX + 1;
  localparam int FRAME_CLKS = COL_CLKS * N_COLS;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       ativar = 1'b0;
  logic       frame_done;
  logic [2:0] contador;
  logic       enable;
  coluna_t    mapa0, mapa1, mapa2, mapa3, mapa4;
  coluna_t    mapa_arr [N_COLS];

  controlador_matriz_if bus ();

  controlador_matriz #(
    .DIV_WIDTH    (16),
    .DIV_MAX      (DIV_MAX),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ativar     (ativar),
    .wr         (bus),
    .frame_done (frame_done),
    .contador   (contador),
    .enable     (enable),
    .mapa0      (mapa0),
    .mapa1      (mapa1),
    .mapa2      (mapa2),
    .mapa3      (mapa3),
    .mapa4      (mapa4)
  );

  always #5 clk = ~clk;

  assign mapa_arr[0] = mapa0;
  assign mapa_arr[1] = mapa1;
  assign mapa_arr[2] = mapa2;
  assign mapa_arr[3] = mapa3;
  assign mapa_arr[4] = mapa4;

  int checks = 0;
  int passes = 0;

  // Reference model: m_t counts clocks since the scan was turned on, so the
  // column is (m_t / 10) % 5 and enable is high when m_t % 10 >= 2.
  bit      m_on      = 1'b0;
  int      m_t       = 0;
  bit      m_pending = 1'b0;
  bit      m_ack     = 1'b0;
  bit      m_done    = 1'b0;
  coluna_t m_back  [N_COLS] = '{default: '0};
  coluna_t m_front [N_COLS] = '{default: '0};

  always @(posedge clk or posedge reset) begin
    bit wrap_now;
    bit ready_pre;
    if (reset) begin
      m_on = 1'b0; m_t = 0; m_pending = 1'b0; m_ack = 1'b0; m_done = 1'b0;
      for (int i = 0; i < N_COLS; i++) begin
        m_back[i] = '0;
        m_front[i] = '0;
      end
    end else begin
      wrap_now  = 1'b0;
      ready_pre = !m_pending;
      if (!m_on) begin
        if (ativar) begin
          m_on = 1'b1;
          m_t  = 0;
        end
      end else if (!ativar) begin
        m_on = 1'b0;
        m_t  = 0;
      end else begin
        m_t++;
        wrap_now = (m_t % FRAME_CLKS == 0);
      end
      m_done = wrap_now;
      m_ack  = 1'b0;
      if (wrap_now && (m_pending || bus.swap_req)) begin
        m_front   = m_back;
        m_pending = 1'b0;
        m_ack     = 1'b1;
      end else if (bus.swap_req) begin
        m_pending = 1'b1;
      end
      if (bus.wr_valid && ready_pre && (int'(bus.wr_col) < N_COLS))
        m_back[bus.wr_col] = bus.wr_data;
    end
  end

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic check_output(input string name);
    logic [41:0] got;
    logic [41:0] exp;
    logic [2:0]  exp_col;
    logic        exp_en;
    exp_col = m_on ? 3'((m_t / COL_CLKS) % N_COLS) : 3'd0;
    exp_en  = m_on && ((m_t % COL_CLKS) >= BLANK);
    got = {contador, enable, frame_done, bus.swap_ack, bus.wr_ready,
           mapa0, mapa1, mapa2, mapa3, mapa4};
    exp = {exp_col, exp_en, m_done, m_ack, !m_pending,
           m_front[0], m_front[1], m_front[2], m_front[3], m_front[4]};
    check_val(name, 64'(got), 64'(exp));
  endtask

  // Advances n clocks, comparing all outputs to the model at each negedge.
  task automatic apply_stimulus(input int n, input string name);
    repeat (n) begin
      @(negedge clk);
      check_output(name);
    end
  endtask

  task automatic wait_model(input int target, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      if (m_on && (m_t % FRAME_CLKS == target)) begin
        found = 1'b1;
        break;
      end
      apply_stimulus(1, name);
    end
    check_val({name, "_reached"}, 64'(found), 64'(1));
  endtask

  task automatic wait_ack(input string name, output int cycles);
    bit found = 1'b0;
    cycles = 0;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      apply_stimulus(1, name);
      cycles++;
      if (bus.swap_ack) begin
        found = 1'b1;
        break;
      end
    end
    check_val({name, "_ack_seen"}, 64'(found), 64'(1));
  endtask

  typedef struct {
    logic [2:0] col;
    coluna_t    data;
    int         check_col;
    coluna_t    exp;
  } vec_t;

  vec_t vecs [6];
  int   cnt_done;
  int   cnt_en;
  int   cycles;

  initial begin
    vecs[0] = '{3'd0, 7'b0000100, 0, 7'b0000100};
    vecs[1] = '{3'd1, 7'b0001100, 1, 7'b0001100};
    vecs[2] = '{3'd2, 7'b1000101, 2, 7'b1000101};
    vecs[3] = '{3'd3, 7'b1110001, 3, 7'b1110001};
    vecs[4] = '{3'd4, 7'b1000011, 4, 7'b1000011};
    vecs[5] = '{3'd5, 7'b1111111, 0, 7'b0000100};

    bus.wr_valid = 1'b0;
    bus.wr_col   = 3'd0;
    bus.wr_data  = '0;
    bus.swap_req = 1'b0;

    // Reset state
    apply_stimulus(2, "reset");
    check_val("reset_outputs",
              64'({contador, enable, frame_done, bus.swap_ack, bus.wr_ready, mapa0, mapa4}),
              64'({3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 7'd0}));
    reset = 1'b0;
    apply_stimulus(3, "idle");

    // Free-running scan: 11 columns observed, 2 frame boundaries
    ativar   = 1'b1;
    cnt_done = 0;
    cnt_en   = 0;
    for (int i = 0; i < 110; i++) begin
      apply_stimulus(1, "scan");
      if (frame_done) cnt_done++;
      if (enable) cnt_en++;
    end
    check_val("frame_done_count", 64'(cnt_done), 64'(2));
    check_val("enable_count", 64'(cnt_en), 64'(88));

    // Table-driven back-buffer writes, including a discarded column 5
    foreach (vecs[i]) begin
      bus.wr_valid = 1'b1;
      bus.wr_col   = vecs[i].col;
      bus.wr_data  = vecs[i].data;
      apply_stimulus(1, "write");
    end
    bus.wr_valid = 1'b0;
    bus.swap_req = 1'b1;
    apply_stimulus(1, "swap_req");
    bus.swap_req = 1'b0;
    check_val("ready_low_pending", 64'(bus.wr_ready), 64'(0));

    // Producer holds a write while the swap is pending
    bus.wr_valid = 1'b1;
    bus.wr_col   = 3'd2;
    bus.wr_data  = 7'h55;
    wait_ack("swap1", cycles);
    check_val("ack_with_frame_done", 64'(frame_done), 64'(1));
    check_val("ready_after_swap", 64'(bus.wr_ready), 64'(1));
    foreach (vecs[i])
      check_val($sformatf("table_mapa%0d_v%0d", vecs[i].check_col, i),
                64'(mapa_arr[vecs[i].check_col]), 64'(vecs[i].exp));
    apply_stimulus(1, "held_write");
    bus.wr_valid = 1'b0;
    bus.swap_req = 1'b1;
    apply_stimulus(1, "swap_req2");
    bus.swap_req = 1'b0;
    wait_ack("swap2", cycles);
    check_val("held_write_mapa2", 64'(mapa2), 64'(7'h55));
    check_val("held_write_mapa0", 64'(mapa0), 64'(7'b0000100));

    // swap_req exactly on the wrap edge
    bus.wr_valid = 1'b1;
    bus.wr_col   = 3'd0;
    bus.wr_data  = 7'h2A;
    apply_stimulus(1, "write_c0");
    bus.wr_valid = 1'b0;
    wait_model(FRAME_CLKS - 1, "to_wrap");
    bus.swap_req = 1'b1;
    apply_stimulus(1, "swap_on_wrap");
    bus.swap_req = 1'b0;
    check_val("wrap_swap_ack", 64'(bus.swap_ack), 64'(1));
    check_val("wrap_swap_ready", 64'(bus.wr_ready), 64'(1));
    check_val("wrap_swap_mapa0", 64'(mapa0), 64'(7'h2A));

    // Turn off in column 3 with a swap pending, then resume
    bus.wr_valid = 1'b1;
    bus.wr_col   = 3'd1;
    bus.wr_data  = 7'h11;
    bus.swap_req = 1'b1;
    apply_stimulus(1, "write_c1");
    bus.wr_valid = 1'b0;
    bus.swap_req = 1'b0;
    wait_model(33, "to_col3");
    ativar = 1'b0;
    apply_stimulus(1, "off");
    check_val("off_enable", 64'(enable), 64'(0));
    check_val("off_contador", 64'(contador), 64'(0));
    check_val("off_pending_kept", 64'(bus.wr_ready), 64'(0));
    apply_stimulus(20, "parked");
    check_val("parked_mapa1", 64'(mapa1), 64'(7'b0001100));
    ativar = 1'b1;
    wait_ack("resume", cycles);
    check_val("resume_swap_delay", 64'(cycles), 64'(FRAME_CLKS + 1));
    check_val("resume_mapa1", 64'(mapa1), 64'(7'h11));

    // Asynchronous reset between edges while enable is high
    wait_model(45, "to_aceso");
    check_val("pre_reset_enable", 64'(enable), 64'(1));
    #2 reset = 1'b1;
    #1;
    check_val("async_reset",
              64'({contador, enable, bus.swap_ack, mapa0, mapa1, mapa2, mapa3, mapa4}),
              64'(0));
    @(negedge clk);
    check_output("in_reset");
    reset  = 1'b0;
    ativar = 1'b0;
    apply_stimulus(3, "post_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
